// File: rtl/mode_counter.sv
// Up/down event counter with programmable modulus, step and limit mode
// (wrap, saturate, one-shot). One-shot parks in HALT until ld or rst.
module mode_counter #(
   parameter int WIDTH   = 8,
   parameter int STEP_W  = 4,
   parameter int MAX_VAL = 2**WIDTH-1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              ld,
   input  logic [WIDTH-1:0]  v,
   input  logic              dir,
   input  logic [STEP_W-1:0] step,
   input  logic [1:0]        mode,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              done
);

   // Wide enough that count + step and count + modulus never overflow
   localparam int SW = WIDTH + STEP_W + 1;
   localparam logic [SW-1:0] MAXV = SW'(MAX_VAL);
   localparam logic [SW-1:0] MODV = SW'(MAX_VAL + 1);

   typedef enum logic {RUN, HALT} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic             tc_nxt;
   logic [SW-1:0]    cnt_x, s, sum, v_x, res;
   logic             hit, lim;

   // Saturate and one-shot share arithmetic; only tc qualification and HALT differ
   assign lim = (mode == 2'b01) || (mode == 2'b10);

   always_comb begin
      cnt_x     = SW'(count);
      v_x       = SW'(v);
      s         = (SW'(step) > MODV) ? MODV : SW'(step);
      sum       = cnt_x + s;
      res       = cnt_x;
      hit       = 1'b0;
      state_nxt = state;
      count_nxt = count;
      tc_nxt    = 1'b0;
      if (ld) begin
         count_nxt = (v_x > MAXV) ? WIDTH'(MAX_VAL) : v;
         state_nxt = RUN;
      end else if (state == HALT) begin
         count_nxt = count;
      end else if (en && (s != '0)) begin
         if (dir) begin
            if (lim) begin
               res = (sum >= MAXV) ? MAXV : sum;
               hit = (mode == 2'b10) ? (sum >= MAXV) : ((cnt_x != MAXV) && (sum >= MAXV));
            end else if (sum > MAXV) begin
               res = sum - MODV;
               hit = 1'b1;
            end else begin
               res = sum;
            end
         end else begin
            if (lim) begin
               res = (s >= cnt_x) ? '0 : (cnt_x - s);
               hit = (mode == 2'b10) ? (s >= cnt_x) : ((cnt_x != '0) && (s >= cnt_x));
            end else if (s > cnt_x) begin
               res = cnt_x + MODV - s;
               hit = 1'b1;
            end else begin
               res = cnt_x - s;
            end
         end
         count_nxt = WIDTH'(res);
         tc_nxt    = hit;
         if ((mode == 2'b10) && hit) state_nxt = HALT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         tc    <= 1'b0;
         state <= RUN;
      end else begin
         count <= count_nxt;
         tc    <= tc_nxt;
         state <= state_nxt;
      end
   end

   assign done = (state == HALT);

endmodule
